pal_cfg_loader: RTL and testbench
=================================

// Module: pal_cfg_loader
// PURPOSE
//  On-chip receiving end of the PAL serial configuration protocol: samples config bits one per clk
//  while the enable pin is high and assembles them into the parallel bitstream for the AND/OR planes.
//  Counts bits, flags completion and flags overrun.
//  Sits between the TT pins (uio_in[0] = cfg bit, uio_in[1] = enable) and the PAL fabric.
// PARAMETERS
//  NUM_INPUTS         8   PAL inputs (ui_in)
//  NUM_OUTPUTS        8   PAL outputs (uo_out)
//  NUM_INTERM_STAGES 16   product terms
//  BITSTREAM_LEN  (localparam) 2*NUM_INPUTS*NUM_INTERM_STAGES + NUM_INTERM_STAGES*NUM_OUTPUTS (384 by default)
//  CNT_W          (localparam) $clog2(BITSTREAM_LEN+1)
// PORTS
//  clk           in   1              config/system clock, rising edge
//  rst_n         in   1              asynchronous, active-low reset
//  cfg_en        in   1              enable pin; a bit is sampled on each clk edge while high
//  cfg_bit       in   1              serial config data
//  cfg_clr       in   1              synchronous restart of loading
//  cfg_out       out  BITSTREAM_LEN  parallel config to the fabric
//  cfg_valid     out  1              full bitstream loaded
//  bit_cnt       out  CNT_W          bits accepted since reset or clear
//  cfg_overflow  out  1              sticky; set if bits arrive after completion
//  readback_bit  out  1              serial readback (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; shift register, bit_cnt, cfg_valid, cfg_overflow, rb_ptr = 0.
//    cfg_out = 0 and readback_bit = 0. Reset during LOAD discards the partial stream.
//  - Bit order: LSB first. sr <= {cfg_bit, sr[LEN-1:1]}.
//    After LEN shifts, the first bit sent is at cfg_out[0] and the last at cfg_out[LEN-1].
//  - FSM states:
//    IDLE --cfg_en--> LOAD. The IDLE-edge bit is shifted in and bit_cnt becomes 1.
//    LOAD: each edge with cfg_en=1 shifts and increments bit_cnt.
//      If cfg_en=0, the bit is not sampled and counting pauses; no timeout.
//    LOAD --edge shifting bit LEN-1--> DONE. cfg_valid=1 and bit_cnt=LEN are visible
//      immediately after that same edge (0-cycle latency after the last bit).
//    DONE: sr is frozen; bit_cnt is held at LEN (saturates).
//      With cfg_en=1 and the macro absent: cfg_overflow <= 1 and the bit is dropped.
//      cfg_overflow stays set until reset or cfg_clr.
//  - cfg_clr (any state) -> IDLE; sr, bit_cnt, cfg_valid, cfg_overflow, rb_ptr cleared next edge.
//    cfg_clr has priority over a simultaneous cfg_en; that bit is dropped.
//  - cfg_out = cfg_valid ? sr : '0. The fabric never sees a partial bitstream.
//  - LEN=1 edge case: IDLE goes directly to DONE on the first bit.
// CONFIGURATION
//  PAL_CFG_READBACK_EN defined:
//    - In DONE, each cfg_en edge advances rb_ptr (0..LEN-1, wraps to 0); readback_bit = sr[rb_ptr].
//    - rb_ptr reads the bitstream in transmit order, and the read is non-destructive.
//    - cfg_overflow is never set; readback_bit = 0 outside DONE.
//  PAL_CFG_READBACK_EN undefined:
//    - No rb_ptr exists; readback_bit is tied to 0.
//    - Overflow behaviour is as in BEHAVIOUR.
// STRUCTURE
//  - Shared header pal_defs.vh holds:
//    - NUM_* default values.
//    - Bitstream length expression (BITSTREAM_LEN).
//    - FSM state encodings ST_IDLE=2'd0, ST_LOAD=2'd1, ST_DONE=2'd2.
//  - One sub-module, pal_cfg_shiftreg: LEN-bit shift register with shift_en, clr, and async rst_n.
//    The FSM, counter, and readback mux live in pal_cfg_loader.
// TESTING
//  1. Reset, then send 384 bits:
//     - bitstream = 0x...C000 pattern with bits 14,15,30,31 set, repeated per output column.
//     - After the 384th edge: cfg_valid=1, bit_cnt=384, cfg_out equals the pattern.
//  2. Send 200 bits, then hold cfg_en=0 for 50 clks:
//     - bit_cnt stays 200 and cfg_valid=0.
//     - Resume with 184 bits -> cfg_valid=1.
//  3. Complete a load, then send 3 more bits with cfg_en=1:
//     - No macro: cfg_overflow=1 and cfg_out unchanged.
//     - With macro: readback_bit returns bits 0,1,2 and cfg_overflow=0.
//  4. Assert rst_n=0 mid-load at bit 100 -> cfg_out=0, bit_cnt=0, state IDLE.
//     Then a full reload succeeds.
//  5. Assert cfg_clr and cfg_en in the same cycle in DONE:
//     - Next cycle: cfg_valid=0, bit_cnt=0, cfg_overflow=0, and the bit is dropped.
//  6. With macro, read back 385 bits after load:
//     - Bit 384 equals bit 0 (rb_ptr wraps).
//     - The stream equals the loaded bitstream.

Source files
------------

// File: rtl/pal_cfg_loader_pkg.sv
// Shared definitions for the PAL configuration loader: default fabric
// dimensions, bitstream length helper and loader FSM state encoding.
package pal_cfg_loader_pkg;

    localparam int PAL_NUM_INPUTS_DEF        = 8;
    localparam int PAL_NUM_OUTPUTS_DEF       = 8;
    localparam int PAL_NUM_INTERM_STAGES_DEF = 16;

    // AND plane holds true+complement of every input per product term,
    // OR plane holds one bit per (product term, output) pair.
    function automatic int pal_bitstream_len(input int n_in, input int n_out, input int n_terms);
        return 2 * n_in * n_terms + n_terms * n_out;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } pal_cfg_state_e;

endpackage

// File: rtl/pal_cfg_shiftreg.sv
// LSB-first serial-in / parallel-out shift register holding the PAL bitstream.
// New bits enter at the top so the first bit sent ends up at q[0].
module pal_cfg_shiftreg #(
    parameter int LEN = 384
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           shift_en,
    input  logic           clr,
    input  logic           din,
    output logic [LEN-1:0] q
);

    logic [LEN-1:0] sr_q, sr_d;
    logic [LEN-1:0] shifted;

    // A one-bit register has nothing to shift down, so it just loads din.
    generate
        if (LEN == 1) begin : g_len1
            assign shifted = din;
        end else begin : g_lenn
            assign shifted = {din, sr_q[LEN-1:1]};
        end
    endgenerate

    // Next value: clear wins over shift, otherwise hold.
    always_comb begin
        sr_d = sr_q;
        if (clr)
            sr_d = '0;
        else if (shift_en)
            sr_d = shifted;
    end

    // Bitstream storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sr_q <= '0;
        else
            sr_q <= sr_d;
    end

    assign q = sr_q;

endmodule

// File: rtl/pal_cfg_loader.sv
// PAL serial configuration receiver. Samples cfg_bit on every clk edge while
// cfg_en is high, assembles the bitstream and only exposes it once complete.
// Optional feature macro: PAL_CFG_READBACK_EN (serial readback in DONE; when
// enabled, extra bits after completion advance the readback pointer instead
// of flagging overflow).
module pal_cfg_loader
    import pal_cfg_loader_pkg::*;
#(
    parameter int NUM_INPUTS        = PAL_NUM_INPUTS_DEF,
    parameter int NUM_OUTPUTS       = PAL_NUM_OUTPUTS_DEF,
    parameter int NUM_INTERM_STAGES = PAL_NUM_INTERM_STAGES_DEF,
    localparam int BITSTREAM_LEN    = pal_bitstream_len(NUM_INPUTS, NUM_OUTPUTS, NUM_INTERM_STAGES),
    localparam int CNT_W            = $clog2(BITSTREAM_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_en,
    input  logic                     cfg_bit,
    input  logic                     cfg_clr,
    output logic [BITSTREAM_LEN-1:0] cfg_out,
    output logic                     cfg_valid,
    output logic [CNT_W-1:0]         bit_cnt,
    output logic                     cfg_overflow,
    output logic                     readback_bit
);

    localparam int LEN = BITSTREAM_LEN;

    pal_cfg_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             shift_en;
    logic [LEN-1:0]   sr;

`ifdef PAL_CFG_READBACK_EN
    localparam int RB_W = (LEN > 1) ? $clog2(LEN) : 1;
    logic [RB_W-1:0] rb_ptr_q, rb_ptr_d;
`endif

    pal_cfg_shiftreg #(.LEN(LEN)) u_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .clr      (cfg_clr),
        .din      (cfg_bit),
        .q        (sr)
    );

    // Next-state, counter and flag logic; cfg_clr overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        shift_en = 1'b0;
`ifdef PAL_CFG_READBACK_EN
        rb_ptr_d = rb_ptr_q;
`endif
        if (cfg_clr) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
`ifdef PAL_CFG_READBACK_EN
            rb_ptr_d = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: if (cfg_en) begin
                    shift_en = 1'b1;
                    cnt_d    = CNT_W'(1);
                    state_d  = (LEN == 1) ? ST_DONE : ST_LOAD;
                end
                ST_LOAD: if (cfg_en) begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LEN - 1))
                        state_d = ST_DONE;
                end
                ST_DONE: if (cfg_en) begin
`ifdef PAL_CFG_READBACK_EN
                    rb_ptr_d = (rb_ptr_q == RB_W'(LEN - 1)) ? '0 : rb_ptr_q + RB_W'(1);
`else
                    ovf_d = 1'b1;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef PAL_CFG_READBACK_EN
    // Readback pointer, walks the stored stream in transmit order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rb_ptr_q <= '0;
        else
            rb_ptr_q <= rb_ptr_d;
    end

    assign readback_bit = (state_q == ST_DONE) ? sr[rb_ptr_q] : 1'b0;
`else
    assign readback_bit = 1'b0;
`endif

    // Valid comes straight from the state so it rises on the last-bit edge.
    assign cfg_valid    = (state_q == ST_DONE);
    assign cfg_out      = cfg_valid ? sr : '0;
    assign bit_cnt      = cnt_q;
    assign cfg_overflow = ovf_q;

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Directed self-checking bench for pal_cfg_loader (default 8/8/16 fabric).
module tb_pal_cfg_loader;

    localparam int LEN   = 384;
    localparam int CNT_W = 9;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_en, cfg_bit, cfg_clr;
    logic [LEN-1:0]   cfg_out;
    logic             cfg_valid, cfg_overflow, readback_bit;
    logic [CNT_W-1:0] bit_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [LEN-1:0] pat_a, pat_b, pat_c;

    pal_cfg_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_en       (cfg_en),
        .cfg_bit      (cfg_bit),
        .cfg_clr      (cfg_clr),
        .cfg_out      (cfg_out),
        .cfg_valid    (cfg_valid),
        .bit_cnt      (bit_cnt),
        .cfg_overflow (cfg_overflow),
        .readback_bit (readback_bit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LEN-1:0] obs, input logic [LEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One enabled edge, then drop enable; outputs sampled 1 time unit after the edge.
    task automatic send_bit(input logic b);
        cfg_en  = 1'b1;
        cfg_bit = b;
        @(posedge clk);
        #1;
        cfg_en  = 1'b0;
    endtask

    task automatic send_range(input logic [LEN-1:0] v, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_bit(v[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cfg_bit = ~cfg_bit;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clr;
        cfg_clr = 1'b1;
        @(posedge clk);
        #1;
        cfg_clr = 1'b0;
    endtask

    initial begin
        // Pattern A: 0xC000C000 in every 32-bit column (bits 14,15,30,31 of each).
        for (int i = 0; i < LEN; i++) begin
            pat_a[i] = ((i % 32) == 14) || ((i % 32) == 15) || ((i % 32) == 30) || ((i % 32) == 31);
            pat_b[i] = 1'($urandom_range(0, 1));
        end
        pat_b[0]   = 1'b1;
        pat_b[LEN-1] = 1'b1;
        pat_c = ~pat_a;

        rst_n = 1'b0; cfg_en = 1'b0; cfg_bit = 1'b0; cfg_clr = 1'b0;
        #12;
        chk("rst_cfg_out", cfg_out, '0);
        chk("rst_bit_cnt", LEN'(bit_cnt), '0);
        chk("rst_valid",   LEN'(cfg_valid), '0);
        chk("rst_ovf",     LEN'(cfg_overflow), '0);
        chk("rst_rb",      LEN'(readback_bit), '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full load of pattern A.
        send_range(pat_a, 0, LEN - 2);
        chk("a_cnt_383",   LEN'(bit_cnt), LEN'(383));
        chk("a_valid_383", LEN'(cfg_valid), '0);
        chk("a_out_383",   cfg_out, '0);
        send_bit(pat_a[LEN-1]);
        chk("a_valid", LEN'(cfg_valid), LEN'(1));
        chk("a_cnt",   LEN'(bit_cnt), LEN'(384));
        chk("a_out",   cfg_out, pat_a);

        // Three extra bits after completion.
`ifdef PAL_CFG_READBACK_EN
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rb_bit%0d", k), LEN'(readback_bit), LEN'(pat_a[k]));
            send_bit(~pat_a[k]);
        end
        chk("extra_ovf", LEN'(cfg_overflow), '0);
`else
        send_range(~pat_a, 0, 2);
        chk("extra_ovf", LEN'(cfg_overflow), LEN'(1));
        chk("extra_rb",  LEN'(readback_bit), '0);
`endif
        chk("extra_out", cfg_out, pat_a);
        chk("extra_cnt", LEN'(bit_cnt), LEN'(384));

        // Clear and enable together in DONE: clear wins, bit dropped.
        cfg_clr = 1'b1; cfg_en = 1'b1; cfg_bit = 1'b1;
        @(posedge clk); #1;
        cfg_clr = 1'b0; cfg_en = 1'b0;
        chk("clr_valid", LEN'(cfg_valid), '0);
        chk("clr_cnt",   LEN'(bit_cnt), '0);
        chk("clr_ovf",   LEN'(cfg_overflow), '0);
        chk("clr_out",   cfg_out, '0);
        send_bit(1'b1);
        chk("clr_idle_cnt", LEN'(bit_cnt), LEN'(1));
        do_clr();

        // Paused load: 200 bits, 50 idle clocks, 184 more.
        send_range(pat_b, 0, 199);
        idle(50);
        chk("pause_cnt",   LEN'(bit_cnt), LEN'(200));
        chk("pause_valid", LEN'(cfg_valid), '0);
        chk("pause_out",   cfg_out, '0);
        send_range(pat_b, 200, LEN - 1);
        chk("resume_valid", LEN'(cfg_valid), LEN'(1));
        chk("resume_out",   cfg_out, pat_b);
        do_clr();

        // Async reset in the middle of a load.
        send_range(pat_a, 0, 99);
        chk("mid_cnt", LEN'(bit_cnt), LEN'(100));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out",   cfg_out, '0);
        chk("mid_rst_cnt",   LEN'(bit_cnt), '0);
        chk("mid_rst_valid", LEN'(cfg_valid), '0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_idle_cnt", LEN'(bit_cnt), '0);
        send_range(pat_c, 0, LEN - 1);
        chk("reload_valid", LEN'(cfg_valid), LEN'(1));
        chk("reload_cnt",   LEN'(bit_cnt), LEN'(384));
        chk("reload_out",   cfg_out, pat_c);

`ifdef PAL_CFG_READBACK_EN
        // Read back 385 bits: whole stream in order, then wrap to bit 0.
        begin
            logic [LEN-1:0] rb;
            logic           rb_wrap;
            rb = '0;
            for (int k = 0; k < LEN; k++) begin
                rb[k] = readback_bit;
                send_bit(1'b0);
            end
            rb_wrap = readback_bit;
            send_bit(1'b0);
            chk("rb_stream", rb, pat_c);
            chk("rb_wrap",   LEN'(rb_wrap), LEN'(pat_c[0]));
            chk("rb_out",    cfg_out, pat_c);
            chk("rb_ovf",    LEN'(cfg_overflow), '0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
